regs_wb_arbiter: RTL and testbench

Shares the single register-file write port (RegWrite/Wt_addr/Wt_data) between two writers: the in-order pipeline writeback stage and an auxiliary multi-cycle writer (divider/load unit). Auxiliary writes are buffered in a small FIFO. The pipeline has priority, but a starvation counter forces the auxiliary writer through within a bounded time. The block also reports pending-write hits so the hazard unit can stall readers of not-yet-written registers.

---
 rtl/regs_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regs_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback
// stage and a FIFO-buffered auxiliary writer, and reports pending-write hazards.
module regs_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  input  logic [4:0]  chk1_addr,
  input  logic [4:0]  chk2_addr,
  output logic        chk1_hit,
  output logic        chk2_hit,
  output logic        RegWrite,
  output logic [4:0]  Wt_addr,
  output logic [31:0] Wt_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  logic [4:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  logic fifo_empty;
  logic wb_req;
  logic force_aux;
  logic grant_aux;
  logic grant_wb;
  logic push;
  logic fifo_hit1;
  logic fifo_hit2;

  assign fifo_empty = (count == '0);
  assign aux_ready  = (count < DEPTH_C);
  assign wb_req     = wb_valid && (wb_addr != 5'd0);
  assign force_aux  = (starve_cnt == LIMIT_C) && !fifo_empty;
  assign grant_aux  = !fifo_empty && (force_aux || !wb_req);
  assign grant_wb   = wb_req && !force_aux;
  assign wb_stall   = wb_req && force_aux;
  // Writes to r0 are architecturally dead, so they are dropped at the door.
  assign push       = aux_valid && aux_ready && (aux_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= aux_addr;
      fifo_data[wr_ptr] <= aux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (grant_aux) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, grant_aux})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Counts consecutive cycles the pipeline beat a non-empty FIFO to the port.
  always_ff @(posedge clk) begin
    if (!rst || fifo_empty || grant_aux) begin
      starve_cnt <= '0;
    end else if (grant_wb && (starve_cnt != LIMIT_C)) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWrite <= 1'b0;
      Wt_addr  <= 5'd0;
      Wt_data  <= 32'd0;
    end else if (grant_aux) begin
      RegWrite <= 1'b1;
      Wt_addr  <= fifo_addr[rd_ptr];
      Wt_data  <= fifo_data[rd_ptr];
    end else if (grant_wb) begin
      RegWrite <= 1'b1;
      Wt_addr  <= wb_addr;
      Wt_data  <= wb_data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  // An entry is live when its distance from the head is below the fill count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    offset    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if ({1'b0, offset} < count) begin
        if (fifo_addr[i] == chk1_addr) fifo_hit1 = 1'b1;
        if (fifo_addr[i] == chk2_addr) fifo_hit2 = 1'b1;
      end
    end
  end

  assign chk1_hit = (chk1_addr != 5'd0) && (fifo_hit1 || (RegWrite && (Wt_addr == chk1_addr)));
  assign chk2_hit = (chk2_addr != 5'd0) && (fifo_hit2 || (RegWrite && (Wt_addr == chk2_addr)));

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed table, hand sequences and a randomized run against a queue-based
// reference model of the write-port arbiter.
module tb_regs_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic [4:0]  chk1_addr;
  logic [4:0]  chk2_addr;
  logic        chk1_hit;
  logic        chk2_hit;
  logic        RegWrite;
  logic [4:0]  Wt_addr;
  logic [31:0] Wt_data;

  int pass_count  = 0;
  int check_count = 0;

  typedef struct {
    logic        rst;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_stall;
    logic        e_ready;
    logic        e_h1;
    logic        e_h2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t tbl [17];
  vec_t rs  [6];

  ent_t        mq[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  regs_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_stall (wb_stall),
    .aux_valid(aux_valid),
    .aux_ready(aux_ready),
    .aux_addr (aux_addr),
    .aux_data (aux_data),
    .chk1_addr(chk1_addr),
    .chk2_addr(chk2_addr),
    .chk1_hit (chk1_hit),
    .chk2_hit (chk2_hit),
    .RegWrite (RegWrite),
    .Wt_addr  (Wt_addr),
    .Wt_data  (Wt_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t idleVec();
    vec_t v;
    v.rst = 1'b1;  v.wv = 1'b0;  v.wa = 5'd0;  v.wd = 32'd0;
    v.av = 1'b0;   v.aa = 5'd0;  v.ad = 32'd0; v.c1 = 5'd0;  v.c2 = 5'd0;
    v.e_stall = 1'b0; v.e_ready = 1'b1; v.e_h1 = 1'b0; v.e_h2 = 1'b0;
    v.e_we = 1'b0; v.e_wa = 5'd0; v.e_wd = 32'd0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    wb_valid  = v.wv;
    wb_addr   = v.wa;
    wb_data   = v.wd;
    aux_valid = v.av;
    aux_addr  = v.aa;
    aux_data  = v.ad;
    chk1_addr = v.c1;
    chk2_addr = v.c2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic checkVec(input string tag, input vec_t v);
    checkOutput({tag, ".wb_stall"},  32'(wb_stall),  32'(v.e_stall));
    checkOutput({tag, ".aux_ready"}, 32'(aux_ready), 32'(v.e_ready));
    checkOutput({tag, ".chk1_hit"},  32'(chk1_hit),  32'(v.e_h1));
    checkOutput({tag, ".chk2_hit"},  32'(chk2_hit),  32'(v.e_h2));
    checkOutput({tag, ".RegWrite"},  32'(RegWrite),  32'(v.e_we));
    checkOutput({tag, ".Wt_addr"},   32'(Wt_addr),   32'(v.e_wa));
    checkOutput({tag, ".Wt_data"},   Wt_data,        v.e_wd);
  endtask

  function automatic logic modelHit(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_we && (m_wa == a)) return 1'b1;
    foreach (mq[k]) if (mq[k].a == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelStep(input vec_t v);
    int   sz;
    logic wreq;
    logic frc;
    logic rdy;
    ent_t e;
    if (!v.rst) begin
      mq.delete();
      m_starve = 0;
      m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
    end else begin
      sz   = mq.size();
      wreq = v.wv && (v.wa != 5'd0);
      frc  = (m_starve == LIMIT) && (sz > 0);
      rdy  = (sz < DEPTH);
      if ((sz > 0) && (frc || !wreq)) begin
        e = mq.pop_front();
        m_we = 1'b1; m_wa = e.a; m_wd = e.d;
        m_starve = 0;
      end else if (wreq) begin
        m_we = 1'b1; m_wa = v.wa; m_wd = v.wd;
        m_starve = (sz > 0) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else begin
        m_we = 1'b0;
        m_starve = 0;
      end
      if (v.av && rdy && (v.aa != 5'd0)) begin
        e.a = v.aa; e.d = v.ad;
        mq.push_back(e);
      end
    end
  endtask

  initial begin
    vec_t v;
    int   s_wa  [9] = '{31, 1, 2, 3, 4, 5, 5, 6, 0};
    int   s_ewa [9] = '{13, 31, 1, 2, 3, 4, 3, 5, 6};
    logic hold;

    //            rst   wv    wa      wd            av    aa      ad          c1      c2      stall ready h1    h2    we    ewa     ewd
    tbl[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99,    5'd9,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[1]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     5'd9,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF};
    tbl[4]  = '{1'b1, 1'b1, 5'd20, 32'h1000,     1'b1, 5'd7,  32'h11,    5'd7,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF};
    tbl[5]  = '{1'b1, 1'b1, 5'd21, 32'h1001,     1'b1, 5'd8,  32'h22,    5'd8,  5'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd20, 32'h1000};
    tbl[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h33,    5'd8,  5'd21, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd21, 32'h1001};
    tbl[7]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd8,  5'd9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  32'h11};
    tbl[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd8,  5'd7,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  32'h22};
    tbl[9]  = '{1'b1, 1'b1, 5'd0,  32'hBAD,      1'b1, 5'd0,  32'hBAD,   5'd0,  5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  32'h22};
    tbl[10] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  32'h22};
    tbl[11] = '{1'b1, 1'b1, 5'd10, 32'hA0,       1'b1, 5'd12, 32'hC0,    5'd12, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  32'h22};
    tbl[12] = '{1'b1, 1'b1, 5'd11, 32'hA1,       1'b1, 5'd13, 32'hC1,    5'd12, 5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'hA0};
    tbl[13] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd14, 32'hC2,    5'd14, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 32'hA1};
    tbl[14] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd14, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'hC0};
    tbl[15] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd13, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'hC1};
    tbl[16] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     5'd13, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 32'hC1};

    rs[0] = '{1'b1, 1'b1, 5'd25, 32'h125, 1'b1, 5'd17, 32'h17, 5'd17, 5'd18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6,  32'h106};
    rs[1] = '{1'b1, 1'b1, 5'd26, 32'h126, 1'b1, 5'd18, 32'h18, 5'd17, 5'd18, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd25, 32'h125};
    rs[2] = '{1'b0, 1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  5'd17, 5'd18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd26, 32'h126};
    rs[3] = '{1'b1, 1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  5'd17, 5'd18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    rs[4] = '{1'b1, 1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  5'd17, 5'd18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    rs[5] = '{1'b1, 1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  5'd17, 5'd18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};

    v = idleVec();
    v.rst = 1'b0;
    applyStimulus(v);
    @(posedge clk);

    $display("[TB] directed table");
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #1;
      checkVec($sformatf("tbl%0d", i), tbl[i]);
      @(posedge clk);
    end

    $display("[TB] starvation sequence");
    for (int i = 0; i < 9; i++) begin
      v = idleVec();
      v.wv = (s_wa[i] != 0);
      v.wa = 5'(s_wa[i]);
      v.wd = 32'h100 | 32'(s_wa[i]);
      if (i == 0) begin
        v.av = 1'b1; v.aa = 5'd3; v.ad = 32'hA5;
      end
      v.c1      = 5'd3;
      v.e_stall = (i == 5);
      v.e_h1    = (i >= 1) && (i <= 6);
      v.e_we    = (i != 0);
      v.e_wa    = 5'(s_ewa[i]);
      v.e_wd    = (i == 0) ? 32'hC1 : ((i == 6) ? 32'hA5 : (32'h100 | 32'(s_ewa[i])));
      @(negedge clk);
      applyStimulus(v);
      #1;
      checkVec($sformatf("starve%0d", i), v);
      @(posedge clk);
    end

    $display("[TB] reset discard sequence");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(rs[i]);
      #1;
      checkVec($sformatf("rstseq%0d", i), rs[i]);
      @(posedge clk);
    end

    $display("[TB] randomized run");
    mq.delete();
    m_starve = 0;
    m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
    hold = 1'b0;
    v = idleVec();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      v.rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      if (!hold) begin
        v.wv = ($urandom_range(0, 9) < 6);
        v.wa = 5'($urandom_range(0, 7));
        v.wd = $urandom;
      end
      v.av = $urandom_range(0, 1) == 1;
      v.aa = 5'($urandom_range(0, 7));
      v.ad = $urandom;
      v.c1 = 5'($urandom_range(0, 7));
      v.c2 = 5'($urandom_range(0, 7));
      v.e_stall = v.wv && (v.wa != 5'd0) && (m_starve == LIMIT) && (mq.size() > 0);
      v.e_ready = (mq.size() < DEPTH);
      v.e_h1    = modelHit(v.c1);
      v.e_h2    = modelHit(v.c2);
      v.e_we    = m_we;
      v.e_wa    = m_wa;
      v.e_wd    = m_wd;
      applyStimulus(v);
      #1;
      checkVec($sformatf("rand%0d", i), v);
      hold = v.e_stall && v.rst;
      @(posedge clk);
      modelStep(v);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
